// File: rtl/latch_load_arbiter.sv
// Round-robin arbiter that time-shares one edge-loaded holding latch between N_REQ requesters.
// Each write runs setup, strobe and hold phases on the latch pins, then acks the winner.
module latch_load_arbiter #(
    parameter int W          = 16,
    parameter int N_REQ      = 4,
    parameter int IDX_W      = 2,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       lat_din,
    output logic               lat_load,
    output logic               busy,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [W-1:0]       shadow
);

    localparam int MAX_CYC = (STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [W-1:0]       din_q, din_d;
    logic [W-1:0]       shadow_q, shadow_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               load_q, load_d;
    logic               busy_q, busy_d;
    logic [N_REQ-1:0]   mask_s;
    logic [N_REQ-1:0]   req_eff_s;
    logic [IDX_W:0]     pick_s;
    logic [IDX_W-1:0]   pick_idx_s;

    // First set request at or after p, wrapping; MSB flags that a winner was found.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] ix;
        res = '0;
        for (int k = 0; k < N_REQ; k++) begin
            ix = IDX_W'((int'(p) + k) % N_REQ);
            if (!res[IDX_W] && r[ix]) begin
                res = {1'b1, ix};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, arbitration and latch-pin sequencing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        din_d    = din_q;
        shadow_d = shadow_q;
        ack_d    = '0;
        load_d   = 1'b0;
        mask_s   = '0;
        // The requester just acked is excluded so a held req cannot win twice in a row.
        if (state_q == S_DONE) begin
            mask_s[grant_q] = 1'b1;
        end else begin
            mask_s = '0;
        end
        req_eff_s  = req & ~mask_s;
        pick_s     = rr_pick(req_eff_s, ptr_q);
        pick_idx_s = pick_s[IDX_W-1:0];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (pick_s[IDX_W]) begin
                    grant_d = pick_idx_s;
                    din_d   = req_data[int'(pick_idx_s)*W +: W];
                    ptr_d   = IDX_W'((int'(pick_idx_s) + 1) % N_REQ);
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d  = S_STROBE;
                load_d   = 1'b1;
                cnt_d    = CNT_W'(STROBE_CYC - 1);
                shadow_d = din_q;
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    load_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    load_d  = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d         = S_DONE;
                    ack_d[grant_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; async reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            din_q    <= '0;
            shadow_q <= '0;
            ack_q    <= '0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            din_q    <= din_d;
            shadow_q <= shadow_d;
            ack_q    <= ack_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign lat_din   = din_q;
    assign lat_load  = load_q;
    assign busy      = busy_q;
    assign grant_idx = grant_q;
    assign shadow    = shadow_q;

endmodule
